// File: rtl/apb_mem_bank_pkg.sv
// mem_pkg: shared definitions for the apb_mem_bank slice.
//   BYTE        - bits per byte lane
//   state_e     - transfer FSM states (IDLE, WAIT, READY)
//   clog2()     - ceiling log2 helper for widths derived from parameters
//   strb_w()    - number of byte lanes for a given data width
package mem_pkg;

    localparam int BYTE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int strb_w(input int data_width);
        return data_width / BYTE;
    endfunction

endpackage

// File: rtl/apb_mem_bank_if.sv
// apb_mem_bank_if: APB signal bundle between a bus master and the memory bank.
//   psel_i, penable_i, pwrite_i       - transfer control (master -> slave)
//   pstrb_i, paddr_i, pwdata_i        - byte strobes, byte address, write data
//   prdata_o, pready_o, pslverr_o     - read data, completion, error (slave -> master)
// Signal suffixes are named from the slave's point of view.
interface apb_mem_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int STRB_W = mem_pkg::strb_w(DATA_WIDTH);

    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [STRB_W-1:0]     pstrb_i;
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic [DATA_WIDTH-1:0] pwdata_i;
    logic [DATA_WIDTH-1:0] prdata_o;
    logic                  pready_o;
    logic                  pslverr_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

endinterface

// File: rtl/apb_mem_bank_array.sv
// mem_array: word storage for apb_mem_bank.
//   clk_i, rst_i         - clock, async active-high reset (read register only)
//   wr_en_i, wr_idx_i    - write enable and word index
//   wr_strb_i, wr_data_i - byte-lane enables and write data
//   rd_en_i, rd_idx_i    - read enable and word index
//   rd_data_o            - registered read data; zero on any edge without rd_en_i
// The storage itself is not reset. The read register doubles as the bus read
// data output, so it is cleared whenever no read is being presented.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    localparam int STRB_W    = strb_w(DATA_WIDTH),
    localparam int IDX_W     = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [STRB_W-1:0]     wr_strb_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (wr_en_i && wr_strb_i[b]) begin
                mem[wr_idx_i][b*BYTE +: BYTE] <= wr_data_i[b*BYTE +: BYTE];
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_en_i) begin
            rd_data_d = mem[rd_idx_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/apb_mem_bank.sv
// apb_mem_bank: APB slave word memory with wait states, byte strobes,
// registered read data and error responses.
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-high reset
//   bus   - apb_mem_bank_if slave modport (psel/penable/pwrite/pstrb/paddr/
//           pwdata in; prdata/pready/pslverr out)
// Outputs are all flop-driven: pready/pslverr here, prdata from the
// storage read register.
//
// state | meaning
// IDLE  | waiting for a setup phase; latches the request when it arrives
// WAIT  | counting down programmed wait states; psel low aborts
// READY | one-cycle completion; a good write commits at the closing edge
module apb_mem_bank
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    apb_mem_bank_if.slave   bus
);

    localparam int STRB_W = strb_w(DATA_WIDTH);
    localparam int OFF    = clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? clog2(DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
    localparam logic [3:0]            WS         = 4'(WAIT_STATES);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;

    logic [ADDR_WIDTH-1:0] idx_full;
    logic [IDX_W-1:0]      idx_now;
    logic                  err_now;
    logic                  setup;
    logic                  rd_en;
    logic [IDX_W-1:0]      rd_idx;
    logic                  wr_en;

    // Full-width index so that high address bits count toward out-of-range.
    assign idx_full = bus.paddr_i >> OFF;
    assign idx_now  = idx_full[IDX_W-1:0];
    assign err_now  = (|(bus.paddr_i & ALIGN_MASK)) || (idx_full >= DEPTH_A);
    assign setup    = bus.psel_i && !bus.penable_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        strb_d    = strb_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        rd_en     = 1'b0;
        rd_idx    = idx_q;
        wr_en     = 1'b0;

        case (state_q)
            IDLE: begin
                // With no wait states the read must be issued from the live
                // address on the setup edge so data lands as READY begins.
                rd_idx = idx_now;
                if (setup) begin
                    idx_d   = idx_now;
                    write_d = bus.pwrite_i;
                    strb_d  = bus.pstrb_i;
                    wdata_d = bus.pwdata_i;
                    err_d   = err_now;
                    cnt_d   = WS;
                    if (WAIT_STATES == 0) begin
                        state_d   = READY;
                        pready_d  = 1'b1;
                        pslverr_d = err_now;
                        rd_en     = !bus.pwrite_i && !err_now;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.psel_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d   = READY;
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    rd_en     = !write_q && !err_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            READY: begin
                state_d = IDLE;
                wr_en   = write_q && !err_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            strb_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en),
        .wr_idx_i  (idx_q),
        .wr_strb_i (strb_q),
        .wr_data_i (wdata_q),
        .rd_en_i   (rd_en),
        .rd_idx_i  (rd_idx),
        .rd_data_o (bus.prdata_o)
    );

    assign bus.pready_o  = pready_q;
    assign bus.pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_mem_bank.sv
// tb_apb_mem_bank: directed bench for apb_mem_bank. Two instances share the
// clock and reset: dut0 with no wait states, dut3 with three. A select bit
// routes the single stimulus bus to one of them.
module tb_apb_mem_bank;
    import mem_pkg::*;

    logic clk;
    logic rst;
    logic which;

    logic        tb_psel, tb_penable, tb_pwrite;
    logic [3:0]  tb_pstrb;
    logic [31:0] tb_paddr, tb_pwdata;

    logic [31:0] out_prdata;
    logic        out_pready, out_pslverr;

    int n_checks;
    int n_errors;

    apb_mem_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
    apb_mem_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus3 ();

    apb_mem_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0.slave)
    );

    apb_mem_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus3.slave)
    );

    assign bus0.psel_i    = tb_psel & ~which;
    assign bus3.psel_i    = tb_psel & which;
    assign bus0.penable_i = tb_penable;
    assign bus3.penable_i = tb_penable;
    assign bus0.pwrite_i  = tb_pwrite;
    assign bus3.pwrite_i  = tb_pwrite;
    assign bus0.pstrb_i   = tb_pstrb;
    assign bus3.pstrb_i   = tb_pstrb;
    assign bus0.paddr_i   = tb_paddr;
    assign bus3.paddr_i   = tb_paddr;
    assign bus0.pwdata_i  = tb_pwdata;
    assign bus3.pwdata_i  = tb_pwdata;

    assign out_prdata  = which ? bus3.prdata_o  : bus0.prdata_o;
    assign out_pready  = which ? bus3.pready_o  : bus0.pready_o;
    assign out_pslverr = which ? bus3.pslverr_o : bus0.pslverr_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge closing READY with
    // the bus idle, so a following call is a back-to-back transfer.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int cycles);
        int n;
        tb_psel    = 1'b1;
        tb_penable = 1'b0;
        tb_pwrite  = wr;
        tb_paddr   = addr;
        tb_pwdata  = wdata;
        tb_pstrb   = strb;
        @(posedge clk); #1;
        tb_penable = 1'b1;
        n = 1;
        while (!out_pready && n < 20) begin
            chk("prdata_zero_in_wait", out_prdata, 32'h0);
            @(posedge clk); #1;
            n++;
        end
        chk("pready_seen", {31'b0, out_pready}, 32'h1);
        rdata  = out_prdata;
        err    = out_pslverr;
        cycles = n + 1;
        @(posedge clk); #1;
        tb_psel    = 1'b0;
        tb_penable = 1'b0;
        tb_pwrite  = 1'b0;
        chk("pready_one_cycle", {31'b0, out_pready}, 32'h0);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic exp_err, input int exp_cycles);
        logic [31:0] rd;
        logic        e;
        int          c;
        apb_xfer(1'b1, addr, wdata, strb, rd, e, c);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
        chk({tag, "_cycles"}, c, exp_cycles);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic exp_err, input int exp_cycles);
        logic [31:0] rd;
        logic        e;
        int          c;
        apb_xfer(1'b0, addr, 32'h0, 4'h0, rd, e, c);
        chk({tag, "_data"}, rd, exp_data);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
        chk({tag, "_cycles"}, c, exp_cycles);
    endtask

    initial begin
        int pulses;
        n_checks   = 0;
        n_errors   = 0;
        which      = 1'b0;
        rst        = 1'b1;
        tb_psel    = 1'b0;
        tb_penable = 1'b0;
        tb_pwrite  = 1'b0;
        tb_pstrb   = 4'h0;
        tb_paddr   = 32'h0;
        tb_pwdata  = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready0",  {31'b0, bus0.pready_o},  32'h0);
        chk("rst_pslverr0", {31'b0, bus0.pslverr_o}, 32'h0);
        chk("rst_prdata0",  bus0.prdata_o,           32'h0);
        chk("rst_pready3",  {31'b0, bus3.pready_o},  32'h0);
        chk("rst_prdata3",  bus3.prdata_o,           32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // No wait states: basic write/read, strobes, zero strobe, boundaries.
        which = 1'b0;
        do_write("wr_10",      32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 2);
        do_read ("rd_10",      32'h10, 32'hDEADBEEF, 1'b0, 2);
        do_write("wr_10_s5",   32'h10, 32'h11223344, 4'h5, 1'b0, 2);
        do_read ("rd_10_s5",   32'h10, 32'hDE22BE44, 1'b0, 2);
        do_write("wr_10_s0",   32'h10, 32'h99999999, 4'h0, 1'b0, 2);
        do_read ("rd_10_s0",   32'h10, 32'hDE22BE44, 1'b0, 2);
        do_write("wr_00",      32'h00, 32'hCAFEF00D, 4'hF, 1'b0, 2);
        do_read ("rd_00",      32'h00, 32'hCAFEF00D, 1'b0, 2);
        do_write("wr_fc",      32'hFC, 32'h12345678, 4'hF, 1'b0, 2);
        do_read ("rd_fc",      32'hFC, 32'h12345678, 1'b0, 2);

        // Error responses leave memory untouched.
        do_read ("rd_misalign", 32'h102, 32'h0, 1'b1, 2);
        do_read ("rd_00_a",     32'h00,  32'hCAFEF00D, 1'b0, 2);
        do_write("wr_oor",      32'h100, 32'hFFFFFFFF, 4'hF, 1'b1, 2);
        do_read ("rd_00_b",     32'h00,  32'hCAFEF00D, 1'b0, 2);
        do_write("wr_misalign", 32'h01,  32'hFFFFFFFF, 4'hF, 1'b1, 2);
        do_read ("rd_00_c",     32'h00,  32'hCAFEF00D, 1'b0, 2);
        do_read ("rd_oor_hi",   32'h8000_0000, 32'h0, 1'b1, 2);

        // Three wait states: access phase is 4 cycles, transfer 5.
        which = 1'b1;
        do_write("ws3_wr_00", 32'h00, 32'hA5A55A5A, 4'hF, 1'b0, 5);
        do_read ("ws3_rd_00", 32'h00, 32'hA5A55A5A, 1'b0, 5);
        do_read ("ws3_rd_err", 32'h102, 32'h0, 1'b1, 5);
        do_write("ws3_wr_20", 32'h20, 32'h11111111, 4'hF, 1'b0, 5);

        // Reset in the middle of a write's wait phase.
        tb_psel    = 1'b1;
        tb_penable = 1'b0;
        tb_pwrite  = 1'b1;
        tb_paddr   = 32'h20;
        tb_pwdata  = 32'h22222222;
        tb_pstrb   = 4'hF;
        @(posedge clk); #1;
        tb_penable = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_pready",  {31'b0, out_pready},  32'h0);
        chk("rst_mid_pslverr", {31'b0, out_pslverr}, 32'h0);
        chk("rst_mid_prdata",  out_prdata,           32'h0);
        chk("rst_mid_state",   32'(dut3.state_q),    32'(IDLE));
        tb_psel    = 1'b0;
        tb_penable = 1'b0;
        tb_pwrite  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_read("ws3_rd_20_rst", 32'h20, 32'h11111111, 1'b0, 5);

        // psel dropped during WAIT: no response, no write.
        tb_psel    = 1'b1;
        tb_penable = 1'b0;
        tb_pwrite  = 1'b1;
        tb_paddr   = 32'h20;
        tb_pwdata  = 32'h33333333;
        tb_pstrb   = 4'hF;
        @(posedge clk); #1;
        tb_penable = 1'b1;
        @(posedge clk); #1;
        tb_psel    = 1'b0;
        tb_penable = 1'b0;
        tb_pwrite  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_pready) pulses++;
        end
        chk("abort_no_pready", pulses, 0);
        chk("abort_state", 32'(dut3.state_q), 32'(IDLE));
        do_read("ws3_rd_20_abort", 32'h20, 32'h11111111, 1'b0, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_mem_bank.md
# apb_mem_bank

Parametrised APB-slave word memory, the next generation of the lab's simple memory block. It serves as matrix/operand storage behind the APB bus of the matrix-multiplication design. Additions over the previous generation:
- full APB setup/access handshake with programmable wait states
- byte-lane write strobes
- registered read data
- slave-error signalling for misaligned or out-of-range addresses

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- ADDR_WIDTH, 32, APB byte-address width.
- DEPTH, 64, number of words stored.
- WAIT_STATES, 0, extra access-phase cycles before pready; range 0..15.
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- pwrite_i  in  1  1 = write, 0 = read.
- pstrb_i  in  DATA_WIDTH/8  byte-lane write enables.
- paddr_i  in  ADDR_WIDTH  byte address.
- pwdata_i  in  DATA_WIDTH  write data.
- prdata_o  out  DATA_WIDTH  read data, valid while pready_o=1 on a read.
- pready_o  out  1  transfer completes this cycle.
- pslverr_o  out  1  error response, valid while pready_o=1.

## Operation
- Word index = paddr_i >> log2(DATA_WIDTH/8).
- A transfer is in error if either holds:
  - the low log2(DATA_WIDTH/8) address bits are nonzero (misaligned);
  - index >= DEPTH.
- FSM states: IDLE, WAIT, READY.
  - IDLE: on an edge with psel_i=1 and penable_i=0 (setup phase):
    - latch address, pwrite_i, pstrb_i, pwdata_i;
    - evaluate error;
    - load wait counter with WAIT_STATES;
    - go to READY if WAIT_STATES=0, else WAIT.
    - On a read, prdata_o is loaded at the edge entering READY.
  - WAIT: counter decrements each edge; at counter=1 go to READY. psel_i=0 here (protocol abort) returns to IDLE with no write and no response.
  - READY: pready_o=1 for exactly one cycle.
    - Write without error: at the closing edge, update only the byte lanes with pstrb_i bit set.
    - Always return to IDLE afterwards.
- pstrb_i all-zero write: legal; memory unchanged; pslverr_o=0.
- Error transfer: no memory update; prdata_o=0; pslverr_o=1 in READY.
- prdata_o is 0 in every cycle except READY of a successful read.
- Memory contents are not reset and are uninitialised after power-up.
- Reset, at any time including mid-transfer:
  - FSM to IDLE; pready_o=0, pslverr_o=0, prdata_o=0;
  - a write not yet committed is dropped.

## Timing
- Access-phase length = WAIT_STATES+1 cycles; total transfer = WAIT_STATES+2 cycles including setup.
- All outputs are registered; no combinational path from APB inputs to outputs.
- Write data becomes visible to a read whose setup phase is the cycle after the write's READY cycle (back-to-back APB).
- Read latency from the setup edge: WAIT_STATES+1 edges.
- No overlap between transfers: a setup phase is only accepted in IDLE.

## Structure
- Package mem_pkg holds:
  - BYTE=8;
  - state enum {IDLE, WAIT, READY};
  - a clog2 helper function;
  - strobe-width derivation DATA_WIDTH/BYTE.
- Sub-module mem_array holds the storage: synchronous byte-enable write port plus synchronous read port, parameters DATA_WIDTH and DEPTH.
- The top level contains the FSM, wait counter, address decode/error check and output registers.

## Test plan
- Write 0xDEADBEEF to addr 0x10 with pstrb=0xF, WAIT_STATES=0, then read 0x10:
  - each transfer takes 2 cycles;
  - prdata_o=0xDEADBEEF, pslverr_o=0.
- Byte strobes: addr 0x10 holds 0xDEADBEEF; write 0x11223344 with pstrb=0x5; read back -> 0xDE22BE44.
- WAIT_STATES=3: read addr 0x0:
  - pready_o low for 3 access cycles, high on the 4th;
  - prdata_o is 0 until pready_o is high.
- Errors:
  - read at 0x102 (misaligned) -> pslverr_o=1, prdata_o=0;
  - write at DEPTH*4=0x100 -> pslverr_o=1;
  - re-read of index 0 after each is unchanged.
- Abort and reset:
  - assert rst_i during WAIT of a write to 0x20 -> outputs 0 within the same cycle, FSM IDLE, later read of 0x20 returns its old value;
  - psel_i dropped mid-WAIT -> no pready_o pulse.
